// File: rtl/sal_sched_pkg.sv
// Shared command encoding and default inter-bank timing for the scheduler slice.
package sal_sched_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        WR  = 3'd3,
        PRE = 3'd4,
        REF = 3'd5
    } cmd_t;

    localparam int unsigned DEF_BK_CNT = 4;
    localparam int unsigned DEF_T_RRD  = 2;
    localparam int unsigned DEF_T_CCD  = 2;
    localparam int unsigned DEF_T_WTR  = 3;
    localparam int unsigned DEF_T_RTW  = 4;

endpackage

// File: rtl/sal_rr_picker.sv
// Round-robin first-set finder: scans req starting at ptr, wrapping modulo N.
module sal_rr_picker #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned W = $clog2(N);

    logic [W-1:0] cand;

    // N is a power of two, so the W-bit add wraps exactly modulo N.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ptr + i[W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sal_bank_arbiter.sv
// One-command-per-cycle arbiter: REF > PRE > COL > ACT, round-robin within each
// class, with the inter-bank tRRD/tCCD/tWTR/tRTW spacing enforced here.
module sal_bank_arbiter
    import sal_sched_pkg::*;
#(
    parameter int unsigned BK_CNT = DEF_BK_CNT,
    parameter int unsigned T_RRD  = DEF_T_RRD,
    parameter int unsigned T_CCD  = DEF_T_CCD,
    parameter int unsigned T_WTR  = DEF_T_WTR,
    parameter int unsigned T_RTW  = DEF_T_RTW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BK_CNT-1:0]         act_req,
    input  logic [BK_CNT-1:0]         rd_req,
    input  logic [BK_CNT-1:0]         wr_req,
    input  logic [BK_CNT-1:0]         pre_req,
    input  logic [BK_CNT-1:0]         ref_req,
    output logic [BK_CNT-1:0]         act_gnt,
    output logic [BK_CNT-1:0]         rd_gnt,
    output logic [BK_CNT-1:0]         wr_gnt,
    output logic [BK_CNT-1:0]         pre_gnt,
    output logic [BK_CNT-1:0]         ref_gnt,
    output logic                      cmd_valid,
    output logic [2:0]                cmd_type,
    output logic [$clog2(BK_CNT)-1:0] cmd_bank
);

    localparam int unsigned BW    = $clog2(BK_CNT);
    localparam int unsigned RRD_W = $clog2(T_RRD + 1);
    localparam int unsigned CCD_W = $clog2(T_CCD + 1);
    localparam int unsigned WTR_W = $clog2(T_WTR + 1);
    localparam int unsigned RTW_W = $clog2(T_RTW + 1);

    localparam logic [RRD_W-1:0] RRD_LD = RRD_W'(T_RRD - 1);
    localparam logic [CCD_W-1:0] CCD_LD = CCD_W'(T_CCD - 1);
    localparam logic [WTR_W-1:0] WTR_LD = WTR_W'(T_WTR - 1);
    localparam logic [RTW_W-1:0] RTW_LD = RTW_W'(T_RTW - 1);

    logic [RRD_W-1:0] rrd_cnt_q, rrd_cnt_d;
    logic [CCD_W-1:0] ccd_cnt_q, ccd_cnt_d;
    logic [WTR_W-1:0] wtr_cnt_q, wtr_cnt_d;
    logic [RTW_W-1:0] rtw_cnt_q, rtw_cnt_d;

    logic [BW-1:0] pre_ptr_q, pre_ptr_d;
    logic [BW-1:0] col_ptr_q, col_ptr_d;
    logic [BW-1:0] act_ptr_q, act_ptr_d;

    logic          cmd_valid_q, cmd_valid_d;
    cmd_t          cmd_type_q, cmd_type_d;
    logic [BW-1:0] cmd_bank_q, cmd_bank_d;

    logic              ref_any, ref_all;
    logic              rd_ok, wr_ok, act_ok;
    logic [BK_CNT-1:0] col_cand, act_cand;
    logic              pre_found, col_found, act_found;
    logic [BW-1:0]     pre_idx, col_idx, act_idx;

    cmd_t          gnt_type;
    logic [BW-1:0] gnt_bank;

    // Eligibility: column candidates are filtered before the shared pointer search.
    always_comb begin
        ref_any  = |ref_req;
        ref_all  = &ref_req;
        rd_ok    = (ccd_cnt_q == '0) && (wtr_cnt_q == '0);
        wr_ok    = (ccd_cnt_q == '0) && (rtw_cnt_q == '0);
        act_ok   = (rrd_cnt_q == '0) && !ref_any;
        col_cand = (rd_ok ? rd_req : '0) | (wr_ok ? wr_req : '0);
        act_cand = act_ok ? act_req : '0;
    end

    sal_rr_picker #(.N(BK_CNT)) u_pre_pick (
        .req   (pre_req),
        .ptr   (pre_ptr_q),
        .found (pre_found),
        .idx   (pre_idx)
    );

    sal_rr_picker #(.N(BK_CNT)) u_col_pick (
        .req   (col_cand),
        .ptr   (col_ptr_q),
        .found (col_found),
        .idx   (col_idx)
    );

    sal_rr_picker #(.N(BK_CNT)) u_act_pick (
        .req   (act_cand),
        .ptr   (act_ptr_q),
        .found (act_found),
        .idx   (act_idx)
    );

    always_comb begin
        gnt_type = NOP;
        gnt_bank = '0;
        if (ref_all) begin
            gnt_type = REF;
        end else if (pre_found) begin
            gnt_type = PRE;
            gnt_bank = pre_idx;
        end else if (col_found) begin
            gnt_bank = col_idx;
            gnt_type = (rd_ok && rd_req[col_idx]) ? RD : WR;
        end else if (act_found) begin
            gnt_type = ACT;
            gnt_bank = act_idx;
        end
    end

    always_comb begin
        act_gnt = '0;
        rd_gnt  = '0;
        wr_gnt  = '0;
        pre_gnt = '0;
        ref_gnt = '0;
        case (gnt_type)
            ACT:     act_gnt[gnt_bank] = 1'b1;
            RD:      rd_gnt[gnt_bank]  = 1'b1;
            WR:      wr_gnt[gnt_bank]  = 1'b1;
            PRE:     pre_gnt[gnt_bank] = 1'b1;
            REF:     ref_gnt           = '1;
            default: ;
        endcase
    end

    // Loads take precedence over the saturating decrement.
    always_comb begin
        rrd_cnt_d = (rrd_cnt_q != '0) ? rrd_cnt_q - 1'b1 : '0;
        ccd_cnt_d = (ccd_cnt_q != '0) ? ccd_cnt_q - 1'b1 : '0;
        wtr_cnt_d = (wtr_cnt_q != '0) ? wtr_cnt_q - 1'b1 : '0;
        rtw_cnt_d = (rtw_cnt_q != '0) ? rtw_cnt_q - 1'b1 : '0;
        pre_ptr_d = pre_ptr_q;
        col_ptr_d = col_ptr_q;
        act_ptr_d = act_ptr_q;
        case (gnt_type)
            ACT: begin
                rrd_cnt_d = RRD_LD;
                act_ptr_d = gnt_bank + 1'b1;
            end
            RD: begin
                ccd_cnt_d = CCD_LD;
                rtw_cnt_d = RTW_LD;
                col_ptr_d = gnt_bank + 1'b1;
            end
            WR: begin
                ccd_cnt_d = CCD_LD;
                wtr_cnt_d = WTR_LD;
                col_ptr_d = gnt_bank + 1'b1;
            end
            PRE: pre_ptr_d = gnt_bank + 1'b1;
            default: ;
        endcase
        cmd_valid_d = (gnt_type != NOP);
        cmd_type_d  = gnt_type;
        cmd_bank_d  = gnt_bank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_cnt_q   <= '0;
            ccd_cnt_q   <= '0;
            wtr_cnt_q   <= '0;
            rtw_cnt_q   <= '0;
            pre_ptr_q   <= '0;
            col_ptr_q   <= '0;
            act_ptr_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= NOP;
            cmd_bank_q  <= '0;
        end else begin
            rrd_cnt_q   <= rrd_cnt_d;
            ccd_cnt_q   <= ccd_cnt_d;
            wtr_cnt_q   <= wtr_cnt_d;
            rtw_cnt_q   <= rtw_cnt_d;
            pre_ptr_q   <= pre_ptr_d;
            col_ptr_q   <= col_ptr_d;
            act_ptr_q   <= act_ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_bank_q  <= cmd_bank_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_type_q;
    assign cmd_bank  = cmd_bank_q;

endmodule

// File: doc/sal_bank_arbiter.md
# sal_bank_arbiter

Per-cycle command arbiter that sits between the per-bank FSMs (request/grant handshake) and the DFI command path. It replaces the pass-through grant logic so that at most one DRAM command issues per cycle. It applies fixed class priority with round-robin fairness inside each class, and it enforces the inter-bank timing constraints (tRRD, tCCD, tWTR, tRTW) that no single bank FSM can see. Per-bank timing (tRCD, tRP, tRAS, and so on) stays in the bank FSMs.

## Interface
- BK_CNT, 4: number of banks (power of 2, ≥2)
- T_RRD, 2: min cycles between ACT grants (≥1)
- T_CCD, 2: min cycles between any two column (RD/WR) grants (≥1)
- T_WTR, 3: min cycles from WR grant to next RD grant (≥1)
- T_RTW, 4: min cycles from RD grant to next WR grant (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- act_req, rd_req, wr_req, pre_req, ref_req  in  BK_CNT each  per-bank request bits, level, held until granted
- act_gnt, rd_gnt, wr_gnt, pre_gnt  out  BK_CNT each  combinational grants, at most one bit set across all grant vectors
- ref_gnt  out  BK_CNT  all-ones when REF is granted, else zero
- cmd_valid  out  1  registered: a command was granted last cycle
- cmd_type  out  3  registered cmd_t of last grant (NOP when none)
- cmd_bank  out  $clog2(BK_CNT)  registered bank of last grant (0 for REF/NOP)

## Operation
- Class priority: REF > PRE > COL (RD/WR) > ACT.
- Arbitration is work-conserving. If a class has requests but none is eligible this cycle, the next class may win.
- **REF**
  - Eligible only when ref_req is all-ones. This means every bank FSM has closed its row.
  - While any ref_req bit is set, ACT is blocked (ACT grants forced to 0).
- **PRE**: always eligible. Uses a round-robin pick over pre_req.
- **COL**
  - RD and WR share one round-robin pointer.
  - A bank is a candidate if it has an eligible rd_req or an eligible wr_req.
  - If the picked bank has both eligible, RD wins.
  - RD is eligible when ccd_cnt==0 and wtr_cnt==0.
  - WR is eligible when ccd_cnt==0 and rtw_cnt==0.
- **ACT**: eligible when rrd_cnt==0 and no ref_req bit is set. Uses a round-robin pick.
- **Round-robin**
  - Each class has its own pointer (pre_ptr, col_ptr, act_ptr).
  - The search starts at the pointer and wraps modulo BK_CNT.
  - On a grant in that class, the pointer becomes the granted bank + 1 (wrapping).
  - Pointers are unchanged when their class does not win.
- **Timing counters** (rrd, ccd, wtr, rtw)
  - Each counter decrements by 1 per cycle until it reaches 0 (saturating).
  - ACT grant loads rrd_cnt = T_RRD-1.
  - RD grant loads ccd_cnt = T_CCD-1 and rtw_cnt = T_RTW-1.
  - WR grant loads ccd_cnt = T_CCD-1 and wtr_cnt = T_WTR-1.
  - A load overrides the decrement in the same cycle.
  - Counter widths are sized with $clog2(T+1).
- A request that drops without a grant is simply not considered; there is no error.

## Timing
- Grants are combinational from the *_req inputs and registered state, in the same cycle.
- cmd_valid, cmd_type and cmd_bank follow the grant by exactly 1 cycle.
- Same-class spacing: consecutive ACT grants are ≥T_RRD cycles apart. Column grants are ≥T_CCD apart. With T=1, back-to-back grants are allowed.
- WR at cycle n: next RD no earlier than n+max(T_CCD,T_WTR).
- RD at cycle n: next WR no earlier than n+max(T_CCD,T_RTW).
- Reset values:
  - all counters 0
  - all pointers 0
  - cmd_valid=0, cmd_type=NOP, cmd_bank=0
  - grants are 0 whenever all requests are 0
- Reset asserted mid-stream: all state clears immediately. On the first cycle after release, every class is eligible.

## Structure
- Package sal_sched_pkg holds:
  - typedef enum logic [2:0] cmd_t {NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5}
  - default timing constants
- Sub-module sal_rr_picker (parameter N) is instantiated three times (PRE, COL, ACT).
  - Inputs: req[N], ptr.
  - Outputs: found, idx. Rotate-and-find-first from ptr.

## Test plan
- After reset, act_req=4'b1111 held → act_gnt grants banks 0,1,2,3 at cycles 0,2,4,6 (T_RRD=2); cmd_type=ACT one cycle after each grant.
- pre_req=4'b0100, rd_req=4'b0001 and act_req=4'b0010 in the same cycle → only pre_gnt[2]=1. The next cycle grants rd_gnt[0]. ACT is granted after that.
- WR to bank 1 at cycle 0, rd_req[1] held from cycle 1 → rd_gnt[1] first at cycle 3 (T_WTR=3). RD at cycle c with wr_req pending → WR first at c+4.
- rd_req=wr_req=4'b1000 → rd_gnt[3] first. wr_gnt[3] follows after T_RTW. col_ptr wraps to 0.
- ref_req=4'b0111 with act_req=4'b1000 → no ACT granted. When ref_req becomes 4'b1111 → ref_gnt=4'b1111 and cmd_type=REF on the next cycle.
- rst_n pulsed low while rrd_cnt=1 and act_ptr=2 → after release, act_req=4'b0001 is granted in the first cycle and act_ptr becomes 1.
